div_unit_allocator: RTL

Allocates and tracks the pipelined-divider units shared by the complex-integer issue lanes. Issue grants a free unit to each divide op and sequences it through start, busy, done and release. Entries killed by a selective flush are reclaimed. A registered free-unit view goes back to the scheduler so it never selects a divide when no unit is free. Sits between the complex-integer issue stage (acquire), the execute stage (start/release) and the recovery manager (flush).

---
 rtl/div_unit_allocator_pkg.sv | 42 ++++
 rtl/div_unit_allocator_if.sv | 32 +++
 rtl/div_unit_allocator_chk.sv | 27 ++
 rtl/div_unit_allocator_slot.sv | 94 +++++++++
 rtl/div_unit_allocator.sv | 93 +++++++++
 5 files changed

// File: rtl/div_unit_allocator_pkg.sv
// Shared types and constants for the divider-unit allocator: unit state encoding,
// index/pointer types and the selective-flush range check.
package div_unit_allocator_pkg;

    localparam int DIV_UNIT_NUM       = 2;
    localparam int ACQ_WIDTH          = 1;
    localparam int DIV_LATENCY        = 8;
    localparam int AL_PTR_WIDTH       = 6;
    localparam int DIV_UNIT_IDX_WIDTH = (DIV_UNIT_NUM > 1) ? $clog2(DIV_UNIT_NUM) : 1;
    localparam int DIV_CNT_WIDTH      = $clog2(DIV_LATENCY);
    localparam int FREE_CNT_WIDTH     = $clog2(DIV_UNIT_NUM) + 1;

    typedef enum logic [1:0] {
        DIV_FREE     = 2'd0,
        DIV_ACQUIRED = 2'd1,
        DIV_BUSY     = 2'd2,
        DIV_DONE     = 2'd3
    } div_unit_state_e;

    typedef logic [DIV_UNIT_IDX_WIDTH-1:0] div_unit_index_t;
    typedef logic [AL_PTR_WIDTH-1:0]       al_ptr_t;
    typedef logic [DIV_CNT_WIDTH-1:0]      div_cnt_t;

    localparam div_cnt_t DIV_CNT_LOAD = div_cnt_t'(DIV_LATENCY - 2);

    // Owner lies in the wrapping range [head, tail); head == tail is an empty range.
    function automatic logic selective_flush_detect(input al_ptr_t ptr, input al_ptr_t head,
                                                    input al_ptr_t tail, input logic flush_all);
        logic hit;
        if (flush_all) begin
            hit = 1'b1;
        end else if (head == tail) begin
            hit = 1'b0;
        end else if (head < tail) begin
            hit = (ptr >= head) && (ptr < tail);
        end else begin
            hit = (ptr >= head) || (ptr < tail);
        end
        return hit;
    endfunction

endpackage

// File: rtl/div_unit_allocator_if.sv
// Scheduler/execute/recovery-side signal bundle of the divider-unit allocator.
interface div_unit_allocator_if;
    import div_unit_allocator_pkg::*;

    logic [ACQ_WIDTH-1:0]      acquire;
    al_ptr_t [ACQ_WIDTH-1:0]   acquireActiveListPtr;
    logic [ACQ_WIDTH-1:0]      acquireGrant;
    div_unit_index_t [ACQ_WIDTH-1:0] acquireUnit;
    logic [DIV_UNIT_NUM-1:0]   start;
    logic [DIV_UNIT_NUM-1:0]   releaseUnit;
    logic                      toRecoveryPhase;
    logic                      flushAllInsns;
    al_ptr_t                   flushRangeHeadPtr;
    al_ptr_t                   flushRangeTailPtr;
    logic                      divFree;
    logic [FREE_CNT_WIDTH-1:0] freeCount;
    logic [DIV_UNIT_NUM-1:0]   busy;
    logic [DIV_UNIT_NUM-1:0]   done;

    modport master (
        output acquire, acquireActiveListPtr, start, releaseUnit,
               toRecoveryPhase, flushAllInsns, flushRangeHeadPtr, flushRangeTailPtr,
        input  acquireGrant, acquireUnit, divFree, freeCount, busy, done
    );

    modport slave (
        input  acquire, acquireActiveListPtr, start, releaseUnit,
               toRecoveryPhase, flushAllInsns, flushRangeHeadPtr, flushRangeTailPtr,
        output acquireGrant, acquireUnit, divFree, freeCount, busy, done
    );

endinterface

// File: rtl/div_unit_allocator_chk.sv
// Protocol checks on the allocator's scheduler and execute-stage inputs.
module div_unit_allocator_chk
    import div_unit_allocator_pkg::*;
(
    input logic                    clk,
    input logic                    rst,
    input logic [ACQ_WIDTH-1:0]    acquire_i,
    input logic [ACQ_WIDTH-1:0]    grant_i,
    input logic [DIV_UNIT_NUM-1:0] start_i,
    input logic [DIV_UNIT_NUM-1:0] release_i,
    input logic [DIV_UNIT_NUM-1:0] acquired_i,
    input logic [DIV_UNIT_NUM-1:0] done_i
);

    a_no_excess_acquire: assert property (@(posedge clk) disable iff (rst)
        ((acquire_i & ~grant_i) == '0))
        else $warning("div_unit_allocator: acquire with no free divider unit");

    a_start_on_acquired: assert property (@(posedge clk) disable iff (rst)
        ((start_i & ~acquired_i) == '0))
        else $warning("div_unit_allocator: start on a unit not in ACQUIRED");

    a_release_on_done: assert property (@(posedge clk) disable iff (rst)
        ((release_i & ~done_i) == '0))
        else $warning("div_unit_allocator: release on a unit not in DONE");

endmodule

// File: rtl/div_unit_allocator_slot.sv
// One divider unit: FREE/ACQUIRED/BUSY/DONE state, latency counter and owner pointer.
module div_unit_slot
    import div_unit_allocator_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    grant_i,
    input  al_ptr_t owner_i,
    input  logic    start_i,
    input  logic    release_i,
    input  logic    flush_i,
    input  logic    flush_all_i,
    input  al_ptr_t flush_head_i,
    input  al_ptr_t flush_tail_i,
    output logic    free_o,
    output logic    acquired_o,
    output logic    busy_o,
    output logic    done_o
);

    div_unit_state_e state_q, state_d;
    div_cnt_t        cnt_q, cnt_d;
    al_ptr_t         owner_q, owner_d;
    logic            flush_hit_s;

    assign flush_hit_s = flush_i && (state_q != DIV_FREE) &&
                         selective_flush_detect(owner_q, flush_head_i, flush_tail_i, flush_all_i);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_FREE;
            cnt_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic; a flush hit overrides everything else for this unit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (flush_hit_s) begin
            state_d = DIV_FREE;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    if (grant_i) begin
                        state_d = DIV_ACQUIRED;
                        owner_d = owner_i;
                    end else begin
                        state_d = DIV_FREE;
                    end
                end
                DIV_ACQUIRED: begin
                    if (start_i) begin
                        state_d = DIV_BUSY;
                        cnt_d   = DIV_CNT_LOAD;
                    end else begin
                        state_d = DIV_ACQUIRED;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q - div_cnt_t'(1);
                    end
                end
                DIV_DONE: begin
                    if (release_i) begin
                        state_d = DIV_FREE;
                    end else begin
                        state_d = DIV_DONE;
                    end
                end
                default: state_d = DIV_FREE;
            endcase
        end
    end

    // Output decode of the registered state
    always_comb begin
        free_o     = (state_q == DIV_FREE);
        acquired_o = (state_q == DIV_ACQUIRED);
        busy_o     = (state_q != DIV_FREE);
        done_o     = (state_q == DIV_DONE);
    end

endmodule

// File: rtl/div_unit_allocator.sv
// Divider-unit allocator: grants free units to acquire lanes in priority order and
// reports the registered free-unit view back to the scheduler.
module div_unit_allocator
    import div_unit_allocator_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    div_unit_allocator_if.slave bus
);

    logic [DIV_UNIT_NUM-1:0]         free_s, acquired_s, busy_s, done_s;
    logic [DIV_UNIT_NUM-1:0]         avail_s, unit_grant_s;
    al_ptr_t [DIV_UNIT_NUM-1:0]      unit_owner_s;
    logic [ACQ_WIDTH-1:0]            lane_grant_s;
    div_unit_index_t [ACQ_WIDTH-1:0] lane_unit_s;
    logic                            found_s;
    logic [FREE_CNT_WIDTH-1:0]       free_cnt_s;

    // Grant encoder: lanes in ascending order take the lowest-index unit still free
    always_comb begin
        avail_s      = free_s;
        unit_grant_s = '0;
        unit_owner_s = '0;
        lane_grant_s = '0;
        lane_unit_s  = '0;
        found_s      = 1'b0;
        for (int l = 0; l < ACQ_WIDTH; l++) begin
            found_s = 1'b0;
            if (bus.acquire[l]) begin
                for (int u = 0; u < DIV_UNIT_NUM; u++) begin
                    if (!found_s && avail_s[u]) begin
                        found_s         = 1'b1;
                        avail_s[u]      = 1'b0;
                        lane_grant_s[l] = 1'b1;
                        lane_unit_s[l]  = div_unit_index_t'(u);
                        unit_grant_s[u] = 1'b1;
                        unit_owner_s[u] = bus.acquireActiveListPtr[l];
                    end else begin
                        found_s = found_s;
                    end
                end
            end else begin
                lane_grant_s[l] = 1'b0;
            end
        end
    end

    // Popcount of free units
    always_comb begin
        free_cnt_s = '0;
        for (int u = 0; u < DIV_UNIT_NUM; u++) begin
            free_cnt_s = free_cnt_s + FREE_CNT_WIDTH'(free_s[u]);
        end
    end

    for (genvar u = 0; u < DIV_UNIT_NUM; u++) begin : g_slot
        div_unit_slot u_slot (
            .clk          (clk),
            .rst          (rst),
            .grant_i      (unit_grant_s[u]),
            .owner_i      (unit_owner_s[u]),
            .start_i      (bus.start[u]),
            .release_i    (bus.releaseUnit[u]),
            .flush_i      (bus.toRecoveryPhase),
            .flush_all_i  (bus.flushAllInsns),
            .flush_head_i (bus.flushRangeHeadPtr),
            .flush_tail_i (bus.flushRangeTailPtr),
            .free_o       (free_s[u]),
            .acquired_o   (acquired_s[u]),
            .busy_o       (busy_s[u]),
            .done_o       (done_s[u])
        );
    end

    div_unit_allocator_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .acquire_i  (bus.acquire),
        .grant_i    (lane_grant_s),
        .start_i    (bus.start),
        .release_i  (bus.releaseUnit),
        .acquired_i (acquired_s),
        .done_i     (done_s)
    );

    assign bus.acquireGrant = lane_grant_s;
    assign bus.acquireUnit  = lane_unit_s;
    assign bus.divFree      = |free_s;
    assign bus.freeCount    = free_cnt_s;
    assign bus.busy         = busy_s;
    assign bus.done         = done_s;

endmodule
